// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and defaults for the AXI-Stream store-and-forward packet FIFO.
// The drop-on-overflow behaviour is selected by AXIS_PKT_FIFO_DROP_EN.
package axis_pkt_fifo_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 1024;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PKT  = 2'd1,
      ST_DROP = 2'd2
   } wr_state_t;

endpackage

// File: rtl/axis_pkt_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous-read port.
// Read data only changes on a read enable, so it doubles as a holding stage.
module sdp_ram
   import axis_pkt_fifo_pkg::*;
#(
   parameter int W     = DEF_DATA_W + 1,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO with two-stage read prefetch.
// Define AXIS_PKT_FIFO_DROP_EN to discard packets that overflow instead of back-pressuring.
module axis_pkt_fifo
   import axis_pkt_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic [DATA_W-1:0]        s_axis_tdata,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic                     s_axis_tlast,
   output logic [DATA_W-1:0]        m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic [$clog2(DEPTH):0]   pkt_cnt,
   output logic [15:0]              drop_cnt,
   output logic [1:0]               wr_state_dbg
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] ONE     = PW'(1);
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   // Handshakes: a beat moves on a port at a rising edge where valid and ready are both high.
   wr_state_t      wr_state;
   logic [PW-1:0]  wr_ptr, wr_commit, rd_ptr, rd_addr;
   logic           full, s_fire, wr_en, pkt_inc;
   logic           a_vld, a_mv, rd_en, m_fire, pkt_dec;
   logic [DATA_W:0] ram_q;

   // rd_ptr frees storage only when a beat leaves the output, so prefetched beats still count.
   assign full   = (wr_ptr - rd_ptr) == DEPTH_P;
   assign s_fire = s_axis_tvalid && s_axis_tready;
   assign wr_en  = s_fire && !full && (wr_state != ST_DROP);
   assign pkt_inc = wr_en && s_axis_tlast;
   assign wr_state_dbg = wr_state;

`ifdef AXIS_PKT_FIFO_DROP_EN
   logic [15:0] drop_cnt_q;
   assign s_axis_tready = !ARESET;
   assign drop_cnt      = drop_cnt_q;
`else
   assign s_axis_tready = !ARESET && !full;
   assign drop_cnt      = 16'd0;
`endif

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_state  <= ST_IDLE;
         wr_ptr    <= '0;
         wr_commit <= '0;
`ifdef AXIS_PKT_FIFO_DROP_EN
         drop_cnt_q <= '0;
      end else if (s_fire && wr_state == ST_DROP) begin
         if (s_axis_tlast) begin
            wr_state <= ST_IDLE;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end else if (s_fire && full) begin
         // Throw away the partial packet and swallow the rest of it.
         wr_ptr <= wr_commit;
         if (s_axis_tlast) begin
            wr_state <= ST_IDLE;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
         end else begin
            wr_state <= ST_DROP;
         end
`endif
      end else if (s_fire) begin
         wr_ptr <= wr_ptr + ONE;
         if (s_axis_tlast) begin
            wr_commit <= wr_ptr + ONE;
            wr_state  <= ST_IDLE;
         end else begin
            wr_state  <= ST_PKT;
         end
      end
   end

   sdp_ram #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_ram (
      .clk   (ACLK),
      .we    (wr_en),
      .waddr (wr_ptr[AW-1:0]),
      .wdata ({s_axis_tlast, s_axis_tdata}),
      .re    (rd_en),
      .raddr (rd_addr[AW-1:0]),
      .rdata (ram_q)
   );

   // Stage A is the RAM read register, stage B the output register.
   assign m_fire  = m_axis_tvalid && m_axis_tready;
   assign pkt_dec = m_fire && m_axis_tlast;
   assign a_mv    = a_vld && (!m_axis_tvalid || m_axis_tready);
   assign rd_en   = (rd_addr != wr_commit) && (!a_vld || a_mv);

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rd_addr       <= '0;
         rd_ptr        <= '0;
         a_vld         <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         pkt_cnt       <= '0;
      end else begin
         if (rd_en)  rd_addr <= rd_addr + ONE;
         if (m_fire) rd_ptr  <= rd_ptr + ONE;
         a_vld <= rd_en || (a_vld && !a_mv);
         if (a_mv) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= ram_q[DATA_W-1:0];
            m_axis_tlast  <= ram_q[DATA_W];
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
         if (pkt_inc && !pkt_dec)      pkt_cnt <= pkt_cnt + ONE;
         else if (!pkt_inc && pkt_dec) pkt_cnt <= pkt_cnt - ONE;
      end
   end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: a DEPTH=256 and a DEPTH=16 instance share one stimulus bus.
// Expectations for the overflow test follow AXIS_PKT_FIFO_DROP_EN.
module tb_axis_pkt_fifo;

   logic clk = 1'b0;
   logic rst;
   logic [7:0] s_tdata;
   logic s_tvalid, s_tlast, m_tready;
   logic sel;  // 0 selects the big instance, 1 the small one

   logic b_sready, b_mvalid, b_mlast; logic [7:0] b_mdata; logic [8:0] b_pkt;
   logic [15:0] b_drop; logic [1:0] b_st;
   logic t_sready, t_mvalid, t_mlast; logic [7:0] t_mdata; logic [4:0] t_pkt;
   logic [15:0] t_drop; logic [1:0] t_st;

   logic o_sready, o_mvalid, o_mlast; logic [7:0] o_mdata; logic [8:0] o_pkt;
   logic [15:0] o_drop; logic [1:0] o_st;

   int n_vec = 0;
   int n_bad = 0;
   logic [8:0] exp_q[$];
   logic mon_en = 1'b0;
   logic prev_stall = 1'b0;

   typedef struct {
      logic rst, v; logic [7:0] d; logic l, rdy;
      logic e_srdy, e_mv; logic [7:0] e_d; logic e_ml; logic [8:0] e_pkt;
   } vec_t;
   vec_t vecs[11];

   always #5 clk = ~clk;

   axis_pkt_fifo #(.DATA_W(8), .DEPTH(256)) u_big (
      .ACLK(clk), .ARESET(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(b_sready), .s_axis_tlast(s_tlast), .m_axis_tdata(b_mdata),
      .m_axis_tvalid(b_mvalid), .m_axis_tready(m_tready), .m_axis_tlast(b_mlast),
      .pkt_cnt(b_pkt), .drop_cnt(b_drop), .wr_state_dbg(b_st));

   axis_pkt_fifo #(.DATA_W(8), .DEPTH(16)) u_small (
      .ACLK(clk), .ARESET(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(t_sready), .s_axis_tlast(s_tlast), .m_axis_tdata(t_mdata),
      .m_axis_tvalid(t_mvalid), .m_axis_tready(m_tready), .m_axis_tlast(t_mlast),
      .pkt_cnt(t_pkt), .drop_cnt(t_drop), .wr_state_dbg(t_st));

   assign o_sready = sel ? t_sready : b_sready;
   assign o_mvalid = sel ? t_mvalid : b_mvalid;
   assign o_mlast  = sel ? t_mlast  : b_mlast;
   assign o_mdata  = sel ? t_mdata  : b_mdata;
   assign o_pkt    = sel ? {4'b0, t_pkt} : b_pkt;
   assign o_drop   = sel ? t_drop   : b_drop;
   assign o_st     = sel ? t_st     : b_st;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst_i, v, input logic [7:0] d, input logic l, rdy,
                               e_srdy, e_mv, input logic [7:0] e_d, input logic e_ml,
                               input logic [8:0] e_pkt);
      vec_t r;
      r.rst = rst_i; r.v = v; r.d = d; r.l = l; r.rdy = rdy;
      r.e_srdy = e_srdy; r.e_mv = e_mv; r.e_d = e_d; r.e_ml = e_ml; r.e_pkt = e_pkt;
      return r;
   endfunction

   // Output scoreboard: every valid beat must match the queue head until it is taken.
   always @(negedge clk) begin
      if (mon_en) begin
         if (o_mvalid) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL unexpected_beat: got %0h, expected none", {o_mlast, o_mdata});
            end else begin
               chk("beat", 32'({o_mlast, o_mdata}), 32'(exp_q[0]));
               if (m_tready) void'(exp_q.pop_front());
            end
         end else if (prev_stall) begin
            n_vec++; n_bad++;
            $display("FAIL valid_dropped: got tvalid 0 during stall, expected 1");
         end
         prev_stall = o_mvalid && !m_tready;
      end
   end

   task automatic do_reset();
      rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; m_tready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_sready", 32'(o_sready), 32'd1);
      chk("rst_mvalid", 32'(o_mvalid), 32'd0);
      chk("rst_mdata",  32'(o_mdata),  32'd0);
      chk("rst_mlast",  32'(o_mlast),  32'd0);
      chk("rst_pkt",    32'(o_pkt),    32'd0);
      chk("rst_drop",   32'(o_drop),   32'd0);
      chk("rst_state",  32'(o_st),     32'd0);
      @(posedge clk); #1;
   endtask

   task automatic send_beat(input logic [7:0] d, input logic l);
      int t = 0;
      s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
      @(negedge clk);
      while (!o_sready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!o_sready) begin
         n_vec++; n_bad++;
         $display("FAIL send_timeout: got tready 0 for 200 cycles, expected 1");
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic send_pkt(input int len, input int base);
      for (int i = 0; i < len; i++) send_beat(8'(base + i), i == len - 1);
   endtask

   task automatic push_pkt(input int len, input int base);
      for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, 8'(base + i)});
   endtask

   task automatic wait_drain(input int budget);
      int t = 0;
      while ((exp_q.size() != 0 || o_mvalid) && t < budget) begin
         @(negedge clk);
         t++;
      end
      if (t >= budget) begin
         n_vec++; n_bad++;
         $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
      end
      @(negedge clk);
      chk("pkt_drained", 32'(o_pkt), 32'd0);
      mon_en = 1'b0; prev_stall = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      // Single-beat packets into DEPTH=16, stalled then released.
      vecs[0]  = mk(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0);
      vecs[1]  = mk(0, 1, 8'h11, 1, 0,  1, 0, 8'h00, 0, 0);
      vecs[2]  = mk(0, 1, 8'h22, 1, 0,  1, 0, 8'h00, 0, 1);
      vecs[3]  = mk(0, 1, 8'h33, 1, 0,  1, 0, 8'h00, 0, 2);
      vecs[4]  = mk(0, 1, 8'h44, 1, 0,  1, 1, 8'h11, 1, 3);
      vecs[5]  = mk(0, 0, 8'h00, 0, 0,  1, 1, 8'h11, 1, 4);
      vecs[6]  = mk(0, 0, 8'h00, 0, 1,  1, 1, 8'h11, 1, 4);
      vecs[7]  = mk(0, 0, 8'h00, 0, 1,  1, 1, 8'h22, 1, 3);
      vecs[8]  = mk(0, 0, 8'h00, 0, 1,  1, 1, 8'h33, 1, 2);
      vecs[9]  = mk(0, 0, 8'h00, 0, 1,  1, 1, 8'h44, 1, 1);
      vecs[10] = mk(0, 0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 0);

      sel = 1'b1;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         rst = vecs[i].rst; s_tvalid = vecs[i].v; s_tdata = vecs[i].d;
         s_tlast = vecs[i].l; m_tready = vecs[i].rdy;
         @(negedge clk);
         chk($sformatf("v%0d_sready", i), 32'(o_sready), 32'(vecs[i].e_srdy));
         chk($sformatf("v%0d_mvalid", i), 32'(o_mvalid), 32'(vecs[i].e_mv));
         if (vecs[i].e_mv) begin
            chk($sformatf("v%0d_mdata", i), 32'(o_mdata), 32'(vecs[i].e_d));
            chk($sformatf("v%0d_mlast", i), 32'(o_mlast), 32'(vecs[i].e_ml));
         end
         chk($sformatf("v%0d_pkt", i), 32'(o_pkt), 32'(vecs[i].e_pkt));
         @(posedge clk); #1;
      end

      // 256-beat packet, sink always ready; first beat two edges after TLAST.
      sel = 1'b0;
      do_reset();
      m_tready = 1'b1;
      push_pkt(256, 0);
      mon_en = 1'b1;
      send_pkt(256, 0);
      @(negedge clk); chk("lat_n0_mvalid", 32'(o_mvalid), 32'd0);
      @(negedge clk); chk("lat_n1_mvalid", 32'(o_mvalid), 32'd0);
      @(negedge clk); chk("lat_n2_mvalid", 32'(o_mvalid), 32'd1);
      chk("lat_n2_mdata", 32'(o_mdata), 32'd0);
      wait_drain(400);

      // Same packet with the sink toggling every cycle.
      do_reset();
      push_pkt(256, 0);
      mon_en = 1'b1;
      fork
         send_pkt(256, 0);
         repeat (800) begin
            @(posedge clk); #1;
            m_tready = !m_tready;
         end
      join
      m_tready = 1'b1;
      wait_drain(100);

      // DEPTH=16, sink stalled, two 10-beat packets.
      sel = 1'b1;
      do_reset();
      push_pkt(10, 8'h10);
`ifndef AXIS_PKT_FIFO_DROP_EN
      push_pkt(10, 8'h20);
`endif
      mon_en = 1'b1;
      send_pkt(10, 8'h10);
      for (int i = 0; i < 6; i++) send_beat(8'(8'h20 + i), 1'b0);
      @(negedge clk);
      chk("ovf_pkt", 32'(o_pkt), 32'd1);
      chk("ovf_state", 32'(o_st), 32'd1);
`ifndef AXIS_PKT_FIFO_DROP_EN
      chk("ovf_sready", 32'(o_sready), 32'd0);
      fork
         for (int i = 6; i < 10; i++) send_beat(8'(8'h20 + i), i == 9);
         begin
            repeat (3) @(posedge clk);
            #1 m_tready = 1'b1;
         end
      join
      @(negedge clk);
      chk("ovf_drop", 32'(o_drop), 32'd0);
`else
      chk("ovf_sready", 32'(o_sready), 32'd1);
      @(posedge clk); #1;
      send_beat(8'h26, 1'b0);
      @(negedge clk);
      chk("ovf_drop_state", 32'(o_st), 32'd2);
      @(posedge clk); #1;
      for (int i = 7; i < 10; i++) send_beat(8'(8'h20 + i), i == 9);
      @(negedge clk);
      chk("ovf_drop", 32'(o_drop), 32'd1);
      chk("ovf_pkt_after", 32'(o_pkt), 32'd1);
      chk("ovf_idle", 32'(o_st), 32'd0);
      @(posedge clk); #1;
      m_tready = 1'b1;
`endif
      wait_drain(200);

      // Reset in the middle of a packet, then a clean 8-beat packet.
      do_reset();
      m_tready = 1'b1;
      push_pkt(8, 8'h60);
      mon_en = 1'b1;
      for (int i = 0; i < 5; i++) send_beat(8'(8'h50 + i), 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_sready", 32'(o_sready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_pkt", 32'(o_pkt), 32'd0);
      chk("midrst_mvalid", 32'(o_mvalid), 32'd0);
      chk("midrst_state", 32'(o_st), 32'd0);
      @(posedge clk); #1;
      send_pkt(8, 8'h60);
      wait_drain(100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected finish within 50000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
